// File: rtl/traffic_pkg.sv
// Shared phase codes, config selectors and reset durations for the traffic phase scheduler.
package traffic_pkg;

  typedef enum logic [2:0] {
    PH_ALL_RED = 3'd0,
    PH_A_GRN   = 3'd1,
    PH_A_YEL   = 3'd2,
    PH_A_CLR   = 3'd3,
    PH_B_GRN   = 3'd4,
    PH_B_YEL   = 3'd5,
    PH_B_CLR   = 3'd6,
    PH_FLASH   = 3'd7
  } phase_t;

  localparam logic [1:0] SEL_YEL = 2'b01;
  localparam logic [1:0] SEL_GRN = 2'b10;
  localparam logic [1:0] SEL_RED = 2'b11;

  localparam int RST_GREEN  = 5;
  localparam int RST_YELLOW = 1;
  localparam int RST_RED    = 1;

  // Returns {led4_r, led4_g, led4_b, led5_r, led5_g, led5_b}; whichever head is not granted shows red.
  function automatic logic [5:0] head_leds(phase_t p);
    case (p)
      PH_A_GRN: return 6'b010_100;
      PH_A_YEL: return 6'b110_100;
      PH_B_GRN: return 6'b100_010;
      PH_B_YEL: return 6'b100_110;
      default:  return 6'b100_100;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module tick_prescaler #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      count <= '0;
    else if (tick) count <= '0;
    else           count <= count + 1'b1;
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-head traffic sequencer with round-robin arbitration and programmable phase durations.
// Optional flashing-yellow mode is enabled by defining FLASH_MODE_EN.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int DUR_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [1:0]       cfg_sel,
  input  logic [DUR_W-1:0] cfg_data,
  output logic             cfg_ready,
  input  logic             req_a,
  input  logic             req_b,
`ifdef FLASH_MODE_EN
  input  logic             flash,
`endif
  output logic             led4_r,
  output logic             led4_g,
  output logic             led4_b,
  output logic             led5_r,
  output logic             led5_g,
  output logic             led5_b,
  output logic [2:0]       phase,
  output logic [DUR_W-1:0] remain
);

  localparam logic [DUR_W-1:0] ONE = DUR_W'(1);

  logic             tick;
  logic             load_cyc;
  phase_t           state_q, state_nxt;
  logic [DUR_W-1:0] remain_q, remain_nxt;
  logic             last_b_q, last_b_nxt;
  logic [5:0]       leds_q, leds_nxt;
  logic [DUR_W-1:0] t_green, t_yellow, t_red;
  logic             req_opp, go_opp, pick_b;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  function automatic logic [DUR_W-1:0] dur_for(phase_t p, logic [DUR_W-1:0] g,
                                               logic [DUR_W-1:0] y, logic [DUR_W-1:0] r);
    logic [DUR_W-1:0] d;
    case (p)
      PH_A_GRN, PH_B_GRN: d = g;
      PH_A_YEL, PH_B_YEL: d = y;
      default:            d = r;
    endcase
    return (d == '0) ? ONE : d;
  endfunction

  // Opposite of the last grant wins unless only the same direction is asking.
  assign req_opp = last_b_q ? req_a : req_b;
  assign go_opp  = req_opp || (!req_a && !req_b);
  assign pick_b  = go_opp ? !last_b_q : last_b_q;

`ifdef FLASH_MODE_EN
  logic flash_d, flash_odd, flash_odd_nxt;
  assign load_cyc      = tick && (remain_q == ONE) && !flash;
  assign flash_odd_nxt = flash ? ((flash_d ? flash_odd : 1'b0) ^ tick) : 1'b0;
`else
  assign load_cyc = tick && (remain_q == ONE);
`endif

  assign cfg_ready = !load_cyc;

  always_comb begin
    state_nxt  = state_q;
    remain_nxt = remain_q;
    last_b_nxt = last_b_q;
`ifdef FLASH_MODE_EN
    if (flash) begin
      state_nxt  = PH_FLASH;
      remain_nxt = '0;
    end else if (flash_d) begin
      state_nxt  = PH_ALL_RED;
      remain_nxt = dur_for(PH_ALL_RED, t_green, t_yellow, t_red);
    end else
`endif
    if (state_q == PH_FLASH) begin
      state_nxt  = PH_ALL_RED;
      remain_nxt = ONE;
    end else if (tick) begin
      if (remain_q > ONE) begin
        remain_nxt = remain_q - 1'b1;
      end else begin
        case (state_q)
          PH_A_GRN: state_nxt = PH_A_YEL;
          PH_A_YEL: state_nxt = PH_A_CLR;
          PH_B_GRN: state_nxt = PH_B_YEL;
          PH_B_YEL: state_nxt = PH_B_CLR;
          default: begin
            state_nxt  = pick_b ? PH_B_GRN : PH_A_GRN;
            last_b_nxt = pick_b;
          end
        endcase
        remain_nxt = dur_for(state_nxt, t_green, t_yellow, t_red);
      end
    end
    leds_nxt = head_leds(state_nxt);
`ifdef FLASH_MODE_EN
    if (flash) leds_nxt = flash_odd_nxt ? 6'b110_110 : 6'b000_000;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= PH_ALL_RED;
      remain_q <= ONE;
      last_b_q <= 1'b1;
      leds_q   <= 6'b100_100;
`ifdef FLASH_MODE_EN
      flash_d   <= 1'b0;
      flash_odd <= 1'b0;
`endif
    end else begin
      state_q  <= state_nxt;
      remain_q <= remain_nxt;
      last_b_q <= last_b_nxt;
      leds_q   <= leds_nxt;
`ifdef FLASH_MODE_EN
      flash_d   <= flash;
      flash_odd <= flash_odd_nxt;
`endif
    end
  end

  // A write cannot land on a load cycle, so a new value only takes effect at a later load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_green  <= DUR_W'(RST_GREEN);
      t_yellow <= DUR_W'(RST_YELLOW);
      t_red    <= DUR_W'(RST_RED);
    end else if (cfg_valid && cfg_ready) begin
      case (cfg_sel)
        SEL_YEL: t_yellow <= cfg_data;
        SEL_GRN: t_green  <= cfg_data;
        SEL_RED: t_red    <= cfg_data;
        default: ;
      endcase
    end
  end

  assign {led4_r, led4_g, led4_b, led5_r, led5_g, led5_b} = leds_q;
  assign phase  = state_q;
  assign remain = remain_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler against a tick-level behavioural model.
module tb_traffic_phase_scheduler;

  localparam int TICK_DIV = 4;
  localparam int DUR_W    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_sel = 2'b00;
  logic [3:0] cfg_data = 4'd0;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;
`ifdef FLASH_MODE_EN
  logic       flash = 1'b0;
`endif
  logic       cfg_ready;
  logic       led4_r, led4_g, led4_b, led5_r, led5_g, led5_b;
  logic [2:0] phase;
  logic [3:0] remain;

  traffic_phase_scheduler #(.TICK_DIV(TICK_DIV), .DUR_W(DUR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_sel   (cfg_sel),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .req_a     (req_a),
    .req_b     (req_b),
`ifdef FLASH_MODE_EN
    .flash     (flash),
`endif
    .led4_r    (led4_r),
    .led4_g    (led4_g),
    .led4_b    (led4_b),
    .led5_r    (led5_r),
    .led5_g    (led5_g),
    .led5_b    (led5_b),
    .phase     (phase),
    .remain    (remain)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Model: phase number, ticks left, durations, who had green last, cycles since last tick.
  int m_phase, m_remain, m_tg, m_ty, m_tr, m_pc;
  bit m_last_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_phase = 0; m_remain = 1; m_pc = 0;
    m_tg = 5; m_ty = 1; m_tr = 1; m_last_b = 1'b1;
  endtask

  function automatic int dur(input int p);
    int d;
    if (p == 1 || p == 4)      d = m_tg;
    else if (p == 2 || p == 5) d = m_ty;
    else                       d = m_tr;
    return (d == 0) ? 1 : d;
  endfunction

  function automatic int next_phase(input int p);
    bit want_b, none, opp_asks;
    if (p == 1 || p == 2 || p == 4 || p == 5) return p + 1;
    none     = !req_a && !req_b;
    opp_asks = m_last_b ? req_a : req_b;
    want_b   = (opp_asks || none) ? !m_last_b : m_last_b;
    return want_b ? 4 : 1;
  endfunction

  function automatic logic [2:0] head(input bit mine, input int p);
    if (!mine) return 3'b100;
    case ((p - 1) % 3)
      0:       return 3'b010;
      1:       return 3'b110;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [5:0] exp_leds(input int p);
    return {head(p >= 1 && p <= 3, p), head(p >= 4 && p <= 6, p)};
  endfunction

  // One clock: check cfg_ready before the edge, advance the model, check registered outputs after.
  task automatic step();
    bit tick, ld, acc;
    int np;
    tick = (m_pc == TICK_DIV - 1);
    ld   = tick && (m_remain == 1);
    check("cfg_ready", 32'(cfg_ready), 32'(!ld));
    acc = cfg_valid && !ld;
    @(posedge clk);
    if (tick) begin
      if (m_remain > 1) m_remain--;
      else begin
        np = next_phase(m_phase);
        if (np == 1) m_last_b = 1'b0;
        else if (np == 4) m_last_b = 1'b1;
        m_phase  = np;
        m_remain = dur(np);
      end
    end
    if (acc) begin
      case (cfg_sel)
        2'b01:   m_ty = int'(cfg_data);
        2'b10:   m_tg = int'(cfg_data);
        2'b11:   m_tr = int'(cfg_data);
        default: ;
      endcase
    end
    m_pc = tick ? 0 : m_pc + 1;
    #1;
    check("phase", 32'(phase), 32'(m_phase));
    check("remain", 32'(remain), 32'(m_remain));
    check("leds", 32'({led4_r, led4_g, led4_b, led5_r, led5_g, led5_b}), 32'(exp_leds(m_phase)));
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [3:0] data);
    cfg_valid = 1'b1; cfg_sel = sel; cfg_data = data;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_phase(input int p, input int rem, input int budget, input string tag);
    int k = 0;
    while (!(m_phase == p && (rem < 0 || m_remain == rem)) && k < budget) begin
      step();
      k++;
    end
    check(tag, 32'(phase), 32'(p));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_phase"}, 32'(phase), 32'd0);
    check({tag, "_remain"}, 32'(remain), 32'd1);
    check({tag, "_leds"}, 32'({led4_r, led4_g, led4_b, led5_r, led5_g, led5_b}), 32'(6'b100_100));
    check({tag, "_ready"}, 32'(cfg_ready), 32'd1);
  endtask

  int seq[$];
  int exp_seq[5] = '{0, 1, 2, 3, 4};

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    model_reset();
    rst = 1'b1;

    // Idle: default alternation starting with A since last grant resets to B.
    seq.push_back(int'(phase));
    for (int i = 0; i < 40; i++) begin
      step();
      if (int'(phase) != seq[$]) seq.push_back(int'(phase));
    end
    for (int i = 0; i < 5; i++)
      check($sformatf("idle_seq%0d", i), (i < seq.size()) ? 32'(seq[i]) : 32'hFFFF, 32'(exp_seq[i]));

    req_a = 1'b1;
    for (int i = 0; i < 150; i++) step();

    req_b = 1'b1;
    for (int i = 0; i < 150; i++) step();

    // Shorten green mid A_GRN: running green keeps its count, next B_GRN uses the new value.
    wait_phase(1, 3, 200, "wait_agrn3");
    cfg_write(2'b10, 4'd2);
    check("agrn_untouched", 32'(remain), 32'd3);
    wait_phase(4, -1, 200, "wait_bgrn");
    check("bgrn_len", 32'(remain), 32'd2);

    cfg_write(2'b01, 4'd3);
    wait_phase(5, -1, 200, "wait_byel");
    check("byel_len3", 32'(remain), 32'd3);
    cfg_write(2'b01, 4'd0);
    cfg_write(2'b00, 4'd9);
    wait_phase(1, -1, 200, "wait_agrn");
    check("sel00_noop", 32'(remain), 32'd2);
    wait_phase(2, -1, 200, "wait_ayel");
    check("yel_zero", 32'(remain), 32'd1);

    for (int k = 0; k < 2500; k++) begin
      if (k % 16 == 0) begin
        req_a = 1'($urandom_range(0, 1));
        req_b = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 31) == 0) begin
        cfg_valid = 1'b1;
        cfg_sel   = 2'($urandom_range(0, 3));
        cfg_data  = 4'($urandom_range(0, 15));
      end
      step();
      cfg_valid = 1'b0;
    end

    // Reset in the middle of B_YEL takes effect without a clock edge.
    req_a = 1'b1; req_b = 1'b1;
    wait_phase(5, -1, 1000, "wait_byel_rst");
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 120; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
Sequences the two RGB traffic heads: led4 is direction A and led5 is direction B. Walks green → yellow → all-red clearance per direction and arbitrates between A and B vehicle requests round-robin. Per-phase durations are programmable through a valid/ready config port. Timing runs off an internal tick prescaler; the block sits between the board buttons/switches and the LED pins.

Parameters:
TICK_DIV, 100_000_000, clk cycles per time unit (one tick); use 4 in simulation.
DUR_W, 4, width of duration registers and remain output.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
cfg_valid  in  1  config write request
cfg_sel  in  2  01=yellow, 10=green, 11=red/clearance, 00=ignored
cfg_data  in  DUR_W  duration in ticks
cfg_ready  out  1  config write accepted when cfg_valid&cfg_ready
req_a  in  1  direction A demand (level)
req_b  in  1  direction B demand (level)
led4_r/led4_g/led4_b  out  1 each  head A
led5_r/led5_g/led5_b  out  1 each  head B
phase  out  3  current phase code
remain  out  DUR_W  ticks left in current phase

Behaviour:
- Reset (rst=0, async): phase=ALL_RED(0); remain=1; prescaler=0; t_green=5, t_yellow=1, t_red=1; last_grant=B; both heads red (r=1,g=0,b=0); cfg_ready=1.
- Phase codes: 0 ALL_RED, 1 A_GRN, 2 A_YEL, 3 A_CLR, 4 B_GRN, 5 B_YEL, 6 B_CLR; 7 unused, recovers to ALL_RED next cycle.
- LED map: GRN g=1 r=0; YEL r=1 g=1; red r=1 g=0. Non-granted head is red. b outputs are constant 0.
- Prescaler: counts 0..TICK_DIV-1; tick pulses for one cycle when count==TICK_DIV-1, then wraps to 0.
- On tick with remain>1: remain decrements.
- On tick with remain==1: phase advances and remain loads the new phase's duration (a stored 0 loads as 1).
- Transitions: A_GRN→A_YEL→A_CLR, B_GRN→B_YEL→B_CLR.
- Arbitration from ALL_RED, A_CLR or B_CLR:
  - go to the direction opposite last_grant if that direction requests, or if neither requests (default alternation);
  - otherwise go to the requesting same direction.
  - Both requesting → opposite of last_grant.
  - last_grant updates on entry to GRN.
- Outputs are registered: LEDs, phase and remain change in the cycle after the tick cycle.
- Config:
  - cfg_ready=0 only in a cycle where tick occurs with remain==1 (phase load); otherwise 1.
  - An accepted write updates the register the next cycle.
  - New values apply from the next phase load; the running phase's remain is untouched.
  - cfg_sel=00 is accepted and discarded.
  - Two writes to the same register: the later one wins.
- Requests are sampled only at arbitration. Request changes mid-phase do not shorten or extend the phase.
- A mid-phase reset returns immediately to the reset state; there is no partial-phase resume.

Optional Feature:
FLASH_MODE_EN:
- Defined: adds input port `flash` (1 bit).
  - While flash=1, both heads show yellow on odd ticks and dark on even ticks; phase=7 (repurposed for flash); remain holds 0; cfg stays operational.
  - On flash falling edge: enter ALL_RED with remain=t_red, then normal sequencing.
  - flash has priority over any phase load in the same cycle.
- Undefined: no `flash` port; phase 7 is always the recover-to-ALL_RED case.

Decomposition:
- Package traffic_pkg: phase code localparams (PH_ALL_RED..PH_B_CLR, PH_FLASH), cfg_sel codes (SEL_YEL, SEL_GRN, SEL_RED), reset durations (RST_GREEN=5, RST_YELLOW=1, RST_RED=1).
- Sub-module tick_prescaler (parameter TICK_DIV, outputs one-cycle tick). FSM, duration registers and arbitration stay in the top.

Test Plan:
- Reset then release, TICK_DIV=4, req_a=req_b=0 → phase 0 for 1 tick, then 4(B? no: last_grant=B so A) 1 for 5 ticks, 2 for 1, 3 for 1, then 4; LEDs match the map each phase.
- req_a=1 held, req_b=0 → phases cycle 1,2,3,1,2,3; head B stays red throughout.
- req_a=req_b=1 → strict alternation 1,2,3,4,5,6,1; each green lasts 5 ticks.
- During A_GRN with remain=3, write cfg_sel=10 cfg_data=2 → current green still lasts 3 more ticks; the next B_GRN lasts 2 ticks. cfg_ready is low exactly on phase-load cycles.
- cfg_sel=01 cfg_data=0 → yellow phases last 1 tick; cfg_sel=00 write has no effect.
- Assert rst mid B_YEL → outputs return to reset values asynchronously, before the next clk edge. With FLASH_MODE_EN, flash pulse 3 ticks → yellow/dark alternation, then phase 0.
